// File: rtl/std_pkg.sv
// Shared definitions for the std_* streaming library cells.
//   std_skid_state_t : 2-bit skid buffer state; 2'b11 is unused and
//                      recovers to ST_EMPTY.
package std_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,  // nothing held
    ST_BUSY  = 2'b01,  // main holds a beat, skid empty
    ST_FULL  = 2'b10   // main and skid both hold a beat
  } std_skid_state_t;

endpackage

// File: rtl/std_dffse.sv
// Load-enable register with synchronous active-high reset to zero.
//   clk_i : clock
//   rst_i : synchronous reset, clears q_o
//   en_i  : load enable
//   d_i   : next value, captured when en_i is high
//   q_o   : registered value
module std_dffse #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     q_q <= '0;
    else if (en_i) q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/std_skid_buf.sv
// Two-entry ready/valid register slice (skid buffer). Both the forward
// path (m_valid/m_data) and the backward path (s_ready) come straight
// from flops, so no input reaches an output combinationally.
//   clk     : clock
//   rst     : synchronous active-high reset, drops any held beats
//   s_valid/s_ready/s_data : upstream (producer) side
//   m_valid/m_ready/m_data : downstream (consumer) side
module std_skid_buf
  import std_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  std_skid_state_t state_q, state_d;
  logic            main_load, skid_load, main_from_skid;
  logic [WIDTH-1:0] main_d, skid_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (s_valid) begin
          main_load = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s_valid && m_ready) begin
          main_load = 1'b1;           // pass-through at full rate
        end else if (s_valid) begin
          skid_load = 1'b1;           // consumer stalled: park in skid
          state_d   = ST_FULL;
        end else if (m_ready) begin
          state_d   = ST_EMPTY;       // main keeps its stale contents
        end
      end
      ST_FULL: begin
        // s_ready is low here, so s_valid is not a transfer.
        if (m_ready) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;   // unused encoding
    endcase
  end

  assign main_d = main_from_skid ? skid_q : s_data;

  std_dffse #(.WIDTH(WIDTH)) u_main (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (main_load),
    .d_i   (main_d),
    .q_o   (m_data)
  );

  std_dffse #(.WIDTH(WIDTH)) u_skid (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (skid_load),
    .d_i   (s_data),
    .q_o   (skid_q)
  );

  // Unused encoding shows neither valid nor ready until it recovers.
  assign m_valid = (state_q == ST_BUSY) || (state_q == ST_FULL);
  assign s_ready = (state_q == ST_EMPTY) || (state_q == ST_BUSY);

endmodule
